// File: rtl/cache_ctrl_wb_if.sv
`default_nettype none
// ============================================================================
//  Module      : cache_ctrl_wb_if
//  Description : Bus bundle for the write-back cache controller. It groups the
//                CPU load/store handshake and the word-serial backing-memory
//                port into one interface.
//                  master : the environment (CPU and memory). It drives
//                           cpu_req/we/addr/wdata and mem_rdata/mem_ack.
//                  slave  : the cache controller. It drives cpu_ready/valid/
//                           rdata/hit and mem_req/we/addr/wdata.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cache_ctrl_wb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // CPU side
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ready;
    logic              cpu_valid;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_hit;

    // Backing-memory side
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ready, cpu_valid, cpu_rdata, cpu_hit,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ready, cpu_valid, cpu_rdata, cpu_hit,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );
endinterface
`default_nettype wire

// File: rtl/cache_ctrl_wb.sv
`default_nettype none
// ============================================================================
//  Module      : cache_ctrl_wb
//  Description : Write-back, write-allocate, N-way set-associative cache
//                controller with true-LRU replacement. It serves one CPU
//                load/store port from a word-serial backing memory. Dirty
//                victims are written back as full lines, and every miss
//                refills a full line.
//  Ports       : clk      - single rising-edge clock
//                reset_n  - asynchronous active-low reset
//                bus      - cache_ctrl_wb_if.slave (CPU + memory signals)
//                stat_hits / stat_misses - 32-bit saturating counters,
//                           present only when CACHE_STATS_EN is defined
//  Config      : `define CACHE_STATS_EN to add the hit/miss counters.
//  Notes       : The bus interface must use the same ADDR_W/DATA_W values as
//                this module. DATA_W >= 16 and LINE_WORDS >= 2 are assumed.
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_ctrl_wb #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int NUM_SETS   = 64,
    parameter int ASSOC      = 4,
    parameter int LINE_WORDS = 8
) (
    input  wire logic      clk,
    input  wire logic      reset_n,
    cache_ctrl_wb_if.slave bus
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]    stat_hits,
    output logic [31:0]    stat_misses
`endif
);
    localparam int WB    = DATA_W / 8;
    localparam int BO_W  = $clog2(WB);
    localparam int WO_W  = $clog2(LINE_WORDS);
    localparam int OFF_W = $clog2(LINE_WORDS * WB);
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
    localparam int WAY_W = $clog2(ASSOC);
    localparam logic [WO_W-1:0]  LAST_WORD = WO_W'(LINE_WORDS - 1);
    localparam logic [WAY_W-1:0] OLDEST    = WAY_W'(ASSOC - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOOKUP    = 3'd1,
        S_WRITEBACK = 3'd2,
        S_FILL      = 3'd3,
        S_RESP      = 3'd4
    } state_t;

    state_t            state_q, state_d;

    // Latched request and transaction bookkeeping
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [WAY_W-1:0]  victim_q;
    logic [WO_W-1:0]   cnt_q;
    logic              cpu_valid_q;
    logic              cpu_hit_q;
    logic [DATA_W-1:0] cpu_rdata_q;

    // Cache storage
    logic [DATA_W-1:0] data_q  [NUM_SETS][ASSOC][LINE_WORDS];
    logic [TAG_W-1:0]  tag_q   [NUM_SETS][ASSOC];
    logic [ASSOC-1:0]  valid_q [NUM_SETS];
    logic [ASSOC-1:0]  dirty_q [NUM_SETS];
    logic [WAY_W-1:0]  age_q   [NUM_SETS][ASSOC];

    // Address fields of the latched request
    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic [WO_W-1:0]   w_word;
    logic              w_unused;

    assign w_idx    = addr_q[OFF_W +: IDX_W];
    assign w_tag    = addr_q[ADDR_W-1 -: TAG_W];
    assign w_word   = addr_q[BO_W +: WO_W];
    assign w_unused = ^addr_q[BO_W-1:0];

    // ------------------------------------------------------------------
    // Parallel tag compare and victim choice for the addressed set
    // ------------------------------------------------------------------
    logic              w_hit;
    logic [WAY_W-1:0]  w_hit_way;
    logic [WAY_W-1:0]  w_victim;

    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        w_victim  = '0;
        for (int w = 0; w < ASSOC; w++) begin
            if (valid_q[w_idx][WAY_W'(w)] && (tag_q[w_idx][WAY_W'(w)] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(w);
            end
        end
        // Oldest way first, then let any invalid way override it. The
        // descending scan makes the lowest-index invalid way win.
        for (int w = ASSOC - 1; w >= 0; w--) begin
            if (age_q[w_idx][WAY_W'(w)] == OLDEST) begin
                w_victim = WAY_W'(w);
            end
        end
        for (int w = ASSOC - 1; w >= 0; w--) begin
            if (!valid_q[w_idx][WAY_W'(w)]) begin
                w_victim = WAY_W'(w);
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and bus outputs
    // ------------------------------------------------------------------
    logic              w_acc_en;   // perform the latched access this cycle
    logic [WAY_W-1:0]  w_acc_way;
    logic              w_xfer;     // a memory word completes this cycle

    always_comb begin
        state_d       = state_q;
        bus.cpu_ready = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        w_acc_en      = 1'b0;
        w_acc_way     = w_hit_way;
        w_xfer        = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                bus.cpu_ready = 1'b1;
                if (bus.cpu_req) begin
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (w_hit) begin
                    w_acc_en = 1'b1;
                    state_d  = S_IDLE;
                end else if (valid_q[w_idx][w_victim] && dirty_q[w_idx][w_victim]) begin
                    state_d  = S_WRITEBACK;
                end else begin
                    state_d  = S_FILL;
                end
            end
            S_WRITEBACK: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = {tag_q[w_idx][victim_q], w_idx, cnt_q, {BO_W{1'b0}}};
                bus.mem_wdata = data_q[w_idx][victim_q][cnt_q];
                w_xfer        = bus.mem_ack;
                if (bus.mem_ack && (cnt_q == LAST_WORD)) begin
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = {w_tag, w_idx, cnt_q, {BO_W{1'b0}}};
                w_xfer       = bus.mem_ack;
                if (bus.mem_ack && (cnt_q == LAST_WORD)) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                w_acc_en  = 1'b1;
                w_acc_way = victim_q;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.cpu_valid = cpu_valid_q;
    assign bus.cpu_hit   = cpu_hit_q;
    assign bus.cpu_rdata = cpu_rdata_q;

    // ------------------------------------------------------------------
    // Control state: request latch, word counter, valid/dirty/LRU
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            victim_q    <= '0;
            cnt_q       <= '0;
            cpu_valid_q <= 1'b0;
            cpu_hit_q   <= 1'b0;
            cpu_rdata_q <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[IDX_W'(s)] <= '0;
                dirty_q[IDX_W'(s)] <= '0;
                for (int w = 0; w < ASSOC; w++) begin
                    age_q[IDX_W'(s)][WAY_W'(w)] <= WAY_W'(w);
                end
            end
        end else begin
            cpu_valid_q <= w_acc_en;
            cpu_hit_q   <= w_acc_en && (state_q == S_LOOKUP);

            if ((state_q == S_IDLE) && bus.cpu_req) begin
                addr_q  <= bus.cpu_addr;
                we_q    <= bus.cpu_we;
                wdata_q <= bus.cpu_wdata;
            end

            if (state_q == S_LOOKUP) begin
                victim_q <= w_victim;
            end

            // The counter wraps to zero after the last word, so it is ready
            // for the fill that follows a writeback.
            if (w_xfer) begin
                cnt_q <= cnt_q + 1'b1;
            end

            // The way is kept invalid while it is being filled, so a fill cut
            // short by reset never leaves a half-written line marked valid.
            if ((state_q == S_FILL) && bus.mem_ack) begin
                valid_q[w_idx][victim_q] <= (cnt_q == LAST_WORD);
                if (cnt_q == LAST_WORD) begin
                    dirty_q[w_idx][victim_q] <= 1'b0;
                end
            end

            if (w_acc_en) begin
                if (we_q) begin
                    dirty_q[w_idx][w_acc_way] <= 1'b1;
                end else begin
                    cpu_rdata_q <= data_q[w_idx][w_acc_way][w_word];
                end
                // True LRU: the accessed way becomes youngest, and every way
                // younger than its old age moves one step older.
                for (int v = 0; v < ASSOC; v++) begin
                    if (WAY_W'(v) == w_acc_way) begin
                        age_q[w_idx][WAY_W'(v)] <= '0;
                    end else if (age_q[w_idx][WAY_W'(v)] < age_q[w_idx][w_acc_way]) begin
                        age_q[w_idx][WAY_W'(v)] <= age_q[w_idx][WAY_W'(v)] + 1'b1;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Line data and tags (no reset; qualified by valid)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if ((state_q == S_FILL) && bus.mem_ack) begin
            data_q[w_idx][victim_q][cnt_q] <= bus.mem_rdata;
            if (cnt_q == LAST_WORD) begin
                tag_q[w_idx][victim_q] <= w_tag;
            end
        end
        if (w_acc_en && we_q) begin
            data_q[w_idx][w_acc_way][w_word] <= wdata_q;
        end
    end

`ifdef CACHE_STATS_EN
    // ------------------------------------------------------------------
    // Saturating hit/miss counters. They update on the same edge that
    // raises cpu_valid.
    // ------------------------------------------------------------------
    logic [31:0] hits_q;
    logic [31:0] misses_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hits_q   <= '0;
            misses_q <= '0;
        end else if (w_acc_en) begin
            if (state_q == S_LOOKUP) begin
                if (hits_q != 32'hFFFF_FFFF) begin
                    hits_q <= hits_q + 32'd1;
                end
            end else begin
                if (misses_q != 32'hFFFF_FFFF) begin
                    misses_q <= misses_q + 32'd1;
                end
            end
        end
    end

    assign stat_hits   = hits_q;
    assign stat_misses = misses_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_ctrl_wb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cache_ctrl_wb
//  Description : Directed self-checking bench for cache_ctrl_wb. The memory
//                model returns addr ^ 0xA5A5_A5A5 and logs writeback words.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_ctrl_wb;
    localparam logic [31:0] PAT = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall;
    int          vectors     = 0;
    int          miscompares = 0;
    int          rd_words    = 0;
    int          wb_words    = 0;
    logic [31:0] wb_addr [64];
    logic [31:0] wb_data [64];

    cache_ctrl_wb_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef CACHE_STATS_EN
    logic [31:0] stat_hits;
    logic [31:0] stat_misses;
`endif

    cache_ctrl_wb #(
        .ADDR_W(32), .DATA_W(32), .NUM_SETS(64), .ASSOC(4), .LINE_WORDS(8)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef CACHE_STATS_EN
        ,
        .stat_hits   (stat_hits),
        .stat_misses (stat_misses)
`endif
    );

    always #5 clk = ~clk;

    // Memory model: zero-wait ack unless stalled
    assign bus.mem_ack   = bus.mem_req && !stall;
    assign bus.mem_rdata = bus.mem_addr ^ PAT;

    always @(posedge clk) begin
        if (bus.mem_req && bus.mem_ack) begin
            if (bus.mem_we) begin
                wb_addr[wb_words[5:0]] <= bus.mem_addr;
                wb_data[wb_words[5:0]] <= bus.mem_wdata;
                wb_words <= wb_words + 1;
            end else begin
                rd_words <= rd_words + 1;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk);
        reset_n     = 1'b0;
        bus.cpu_req = 1'b0;
        stall       = 1'b0;
        @(negedge clk);
        reset_n     = 1'b1;
    endtask

    // One CPU access. lat counts cycles from the request cycle to the
    // cycle that shows cpu_valid.
    task automatic access(input logic we, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic hit, output int lat);
        int guard;
        @(negedge clk);
        guard = 0;
        while (!bus.cpu_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
        lat = 0;
        do begin
            @(negedge clk);
            bus.cpu_req = 1'b0;
            lat++;
        end while (!bus.cpu_valid && lat < 200);
        rd  = bus.cpu_rdata;
        hit = bus.cpu_hit;
        vectors++;
        if (!bus.cpu_valid) begin
            miscompares++;
            $display("FAIL access_timeout addr=%h: cpu_valid absent after %0d cycles", a, lat);
        end
    endtask

    task automatic test_reset();
        reset_n       = 1'b0;
        stall         = 1'b0;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        #2;
        vectors++; if (bus.cpu_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready got=%b exp=1", bus.cpu_ready); end
        vectors++; if (bus.cpu_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got=%b exp=0", bus.cpu_valid); end
        vectors++; if (bus.cpu_hit !== 1'b0) begin miscompares++; $display("FAIL rst_hit got=%b exp=0", bus.cpu_hit); end
        vectors++; if (bus.cpu_rdata !== 32'h0) begin miscompares++; $display("FAIL rst_rdata got=%h exp=0", bus.cpu_rdata); end
        vectors++; if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL rst_mem_req got=%b exp=0", bus.mem_req); end
        vectors++; if (bus.mem_we !== 1'b0) begin miscompares++; $display("FAIL rst_mem_we got=%b exp=0", bus.mem_we); end
        vectors++; if (bus.mem_addr !== 32'h0) begin miscompares++; $display("FAIL rst_mem_addr got=%h exp=0", bus.mem_addr); end
`ifdef CACHE_STATS_EN
        vectors++; if (stat_hits !== 32'h0) begin miscompares++; $display("FAIL rst_stat_hits got=%h exp=0", stat_hits); end
        vectors++; if (stat_misses !== 32'h0) begin miscompares++; $display("FAIL rst_stat_misses got=%h exp=0", stat_misses); end
`endif
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_load_miss();
        logic [31:0] rd; logic hit; int lat; int r0, w0;
        r0 = rd_words; w0 = wb_words;
        access(1'b0, 32'h0000_1000, 32'h0, rd, hit, lat);
        vectors++; if (rd !== 32'hA5A5_B5A5) begin miscompares++; $display("FAIL miss_rdata got=%h exp=a5a5b5a5", rd); end
        vectors++; if (hit !== 1'b0) begin miscompares++; $display("FAIL miss_hit got=%b exp=0", hit); end
        vectors++; if (lat != 11) begin miscompares++; $display("FAIL miss_latency got=%0d exp=11", lat); end
        vectors++; if (rd_words - r0 != 8) begin miscompares++; $display("FAIL miss_refill_words got=%0d exp=8", rd_words - r0); end
        vectors++; if (wb_words - w0 != 0) begin miscompares++; $display("FAIL miss_wb_words got=%0d exp=0", wb_words - w0); end
        access(1'b0, 32'h0000_1000, 32'h0, rd, hit, lat);
        vectors++; if (rd !== 32'hA5A5_B5A5) begin miscompares++; $display("FAIL rehit_rdata got=%h exp=a5a5b5a5", rd); end
        vectors++; if (hit !== 1'b1) begin miscompares++; $display("FAIL rehit_hit got=%b exp=1", hit); end
        vectors++; if (lat != 2) begin miscompares++; $display("FAIL rehit_latency got=%0d exp=2", lat); end
    endtask

    task automatic test_store_hit();
        logic [31:0] rd; logic hit; int lat; int r0, w0;
        r0 = rd_words; w0 = wb_words;
        access(1'b1, 32'h0000_1004, 32'hDEAD_BEEF, rd, hit, lat);
        vectors++; if (hit !== 1'b1) begin miscompares++; $display("FAIL st_hit got=%b exp=1", hit); end
        vectors++; if (lat != 2) begin miscompares++; $display("FAIL st_latency got=%0d exp=2", lat); end
        access(1'b0, 32'h0000_1004, 32'h0, rd, hit, lat);
        vectors++; if (rd !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL st_ld_rdata got=%h exp=deadbeef", rd); end
        vectors++; if (hit !== 1'b1) begin miscompares++; $display("FAIL st_ld_hit got=%b exp=1", hit); end
        access(1'b0, 32'h0000_1008, 32'h0, rd, hit, lat);
        vectors++; if (rd !== 32'hA5A5_B5AD) begin miscompares++; $display("FAIL st_neighbour got=%h exp=a5a5b5ad", rd); end
        vectors++; if ((rd_words != r0) || (wb_words != w0)) begin
            miscompares++; $display("FAIL st_no_traffic got rd=%0d wb=%0d exp 0 0", rd_words - r0, wb_words - w0);
        end
    endtask

    task automatic test_evict();
        logic [31:0] rd; logic hit; int lat; int r0, w0, k;
        logic [31:0] a, ed;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            a  = 32'((i + 1) << 12) + 32'd4;
            r0 = rd_words; w0 = wb_words;
            access(1'b1, a, 32'hAAAA_0000 | 32'(i), rd, hit, lat);
            vectors++; if (hit !== 1'b0) begin miscompares++; $display("FAIL ev_hit%0d got=%b exp=0", i, hit); end
            vectors++; if (rd_words - r0 != 8) begin miscompares++; $display("FAIL ev_fill%0d got=%0d exp=8", i, rd_words - r0); end
            vectors++;
            if (wb_words - w0 != ((i == 4) ? 8 : 0)) begin
                miscompares++; $display("FAIL ev_wbcnt%0d got=%0d exp=%0d", i, wb_words - w0, (i == 4) ? 8 : 0);
            end
        end
        for (int j = 0; j < 8; j++) begin
            k  = (w0 + j) % 64;
            a  = 32'h0000_1000 + 32'(4 * j);
            ed = (j == 1) ? 32'hAAAA_0000 : (a ^ PAT);
            vectors++; if (wb_addr[k] !== a) begin miscompares++; $display("FAIL ev_wbaddr%0d got=%h exp=%h", j, wb_addr[k], a); end
            vectors++; if (wb_data[k] !== ed) begin miscompares++; $display("FAIL ev_wbdata%0d got=%h exp=%h", j, wb_data[k], ed); end
        end
`ifdef CACHE_STATS_EN
        vectors++; if (stat_misses !== 32'd5) begin miscompares++; $display("FAIL ev_stat_misses got=%0d exp=5", stat_misses); end
        vectors++; if (stat_hits !== 32'd0) begin miscompares++; $display("FAIL ev_stat_hits got=%0d exp=0", stat_hits); end
`endif
    endtask

    task automatic test_lru();
        logic [31:0] rd; logic hit; int lat; int w0;
        do_reset();
        w0 = wb_words;
        for (int i = 1; i <= 4; i++) begin
            access(1'b0, 32'(i << 12), 32'h0, rd, hit, lat);
        end
        access(1'b0, 32'h0000_1000, 32'h0, rd, hit, lat);
        vectors++; if (hit !== 1'b1) begin miscompares++; $display("FAIL lru_reread_a got=%b exp=1", hit); end
        access(1'b0, 32'h0000_5000, 32'h0, rd, hit, lat);
        vectors++; if (hit !== 1'b0) begin miscompares++; $display("FAIL lru_e_hit got=%b exp=0", hit); end
        vectors++; if (rd !== 32'hA5A5_F5A5) begin miscompares++; $display("FAIL lru_e_rdata got=%h exp=a5a5f5a5", rd); end
        access(1'b0, 32'h0000_1000, 32'h0, rd, hit, lat);
        vectors++; if (hit !== 1'b1) begin miscompares++; $display("FAIL lru_a_kept got=%b exp=1", hit); end
        access(1'b0, 32'h0000_2000, 32'h0, rd, hit, lat);
        vectors++; if (hit !== 1'b0) begin miscompares++; $display("FAIL lru_b_evicted got=%b exp=0", hit); end
        vectors++; if (wb_words != w0) begin miscompares++; $display("FAIL lru_clean_wb got=%0d exp=0", wb_words - w0); end
    endtask

    task automatic test_fill_stall();
        logic [31:0] a0; int t, r0, nvalid;
        do_reset();
        r0 = rd_words;
        stall = 1'b1;
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h0000_1000; bus.cpu_wdata = '0;
        @(negedge clk);
        bus.cpu_req = 1'b0;
        t = 0;
        while (!bus.mem_req && t < 20) begin @(negedge clk); t++; end
        vectors++; if (bus.mem_req !== 1'b1) begin miscompares++; $display("FAIL stall_mem_req got=%b exp=1", bus.mem_req); end
        a0 = bus.mem_addr;
        vectors++; if (a0 !== 32'h0000_1000) begin miscompares++; $display("FAIL stall_addr0 got=%h exp=00001000", a0); end
        for (int i = 0; i < 20; i++) begin
            vectors++; if (bus.mem_addr !== a0) begin miscompares++; $display("FAIL stall_addr_stable c%0d got=%h exp=%h", i, bus.mem_addr, a0); end
            vectors++; if (bus.cpu_ready !== 1'b0) begin miscompares++; $display("FAIL stall_ready c%0d got=%b exp=0", i, bus.cpu_ready); end
            if (i == 5) begin bus.cpu_req = 1'b1; bus.cpu_addr = 32'h0000_7000; end
            if (i == 6) bus.cpu_req = 1'b0;
            @(negedge clk);
        end
        stall = 1'b0;
        t = 0;
        while (!bus.cpu_valid && t < 50) begin @(negedge clk); t++; end
        vectors++; if (bus.cpu_valid !== 1'b1) begin miscompares++; $display("FAIL stall_valid got=%b exp=1", bus.cpu_valid); end
        vectors++; if (bus.cpu_rdata !== 32'hA5A5_B5A5) begin miscompares++; $display("FAIL stall_rdata got=%h exp=a5a5b5a5", bus.cpu_rdata); end
        vectors++; if (bus.cpu_hit !== 1'b0) begin miscompares++; $display("FAIL stall_hit got=%b exp=0", bus.cpu_hit); end
        nvalid = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.cpu_valid) nvalid++;
        end
        vectors++; if (nvalid != 0) begin miscompares++; $display("FAIL stall_extra_req got=%0d valids exp=0", nvalid); end
        vectors++; if (rd_words - r0 != 8) begin miscompares++; $display("FAIL stall_refill_words got=%0d exp=8", rd_words - r0); end
    endtask

    task automatic test_reset_wb();
        logic [31:0] rd; logic hit; int lat; int t, w0;
        do_reset();
        access(1'b1, 32'h0000_1000, 32'h1234_5678, rd, hit, lat);
        for (int i = 2; i <= 4; i++) access(1'b0, 32'(i << 12), 32'h0, rd, hit, lat);
        stall = 1'b1;
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h0000_5000;
        @(negedge clk);
        bus.cpu_req = 1'b0;
        t = 0;
        while (!bus.mem_req && t < 20) begin @(negedge clk); t++; end
        vectors++; if (bus.mem_we !== 1'b1) begin miscompares++; $display("FAIL rwb_in_wb got=%b exp=1", bus.mem_we); end
        vectors++; if (bus.mem_addr !== 32'h0000_1000) begin miscompares++; $display("FAIL rwb_addr got=%h exp=00001000", bus.mem_addr); end
        #2 reset_n = 1'b0;
        #1;
        vectors++; if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL rwb_async_mem_req got=%b exp=0", bus.mem_req); end
        vectors++; if (bus.cpu_ready !== 1'b1) begin miscompares++; $display("FAIL rwb_async_ready got=%b exp=1", bus.cpu_ready); end
        @(negedge clk);
        reset_n = 1'b1;
        stall   = 1'b0;
        w0 = wb_words;
        access(1'b0, 32'h0000_1000, 32'h0, rd, hit, lat);
        vectors++; if (hit !== 1'b0) begin miscompares++; $display("FAIL rwb_reload_hit got=%b exp=0", hit); end
        vectors++; if (rd !== 32'hA5A5_B5A5) begin miscompares++; $display("FAIL rwb_reload_rdata got=%h exp=a5a5b5a5", rd); end
        vectors++; if (wb_words != w0) begin miscompares++; $display("FAIL rwb_no_wb got=%0d exp=0", wb_words - w0); end
    endtask

    initial begin
        test_reset();
        test_load_miss();
        test_store_hit();
        test_evict();
        test_lru();
        test_fill_stall();
        test_reset_wb();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
